// File: rtl/maf_pkg.sv
// Shared helpers for the MAF datapath.
//   clog2       : ceiling log2 usable in parameter expressions
//   ow_of       : reduction-tree output width, W + clog2(N_OPS)
//   levels_of   : number of 4-2 compressor levels, clog2(N_OPS) - 1
//   stage_base  : first register-bank slot written by a given level
//   extend_op   : sign/zero extension of one operand to MAX_OW bits
package maf_pkg;

  // Widest redundant vector any tree instance may produce.
  localparam int MAX_OW = 64;

  localparam int DEF_W     = 16;
  localparam int DEF_N_OPS = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ow_of(input int w, input int n_ops);
    return w + clog2(n_ops);
  endfunction

  function automatic int levels_of(input int n_ops);
    return clog2(n_ops) - 1;
  endfunction

  // All level outputs live in one flat bank: level l owns slots
  // [stage_base(n, l), stage_base(n, l + 1)), i.e. n >> (l + 1) vectors.
  function automatic int stage_base(input int n_ops, input int lvl);
    return n_ops - (n_ops >> lvl);
  endfunction

  // op arrives zero-padded above bit w-1; the upper bits are rewritten
  // with the operand's sign bit or with zeros.
  function automatic logic [MAX_OW-1:0] extend_op(input logic [MAX_OW-1:0] op,
                                                  input int               w,
                                                  input bit               is_signed);
    logic [MAX_OW-1:0] r;
    r = op;
    for (int i = 0; i < MAX_OW; i++) begin
      if (i >= w) r[i] = is_signed & op[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Streaming bus of the carry-save reduction tree.
//   in_valid/in_ready   : operand-side handshake
//   in_ops              : N_OPS packed operands, operand k at [k*W +: W]
//   in_tag              : side-band tag travelling with the operands
//   out_valid/out_ready : result-side handshake
//   sum_o/carry_o       : redundant result, OW = W + clog2(N_OPS) bits
//   tag_o               : tag of the presented result
// master = producer/consumer environment, slave = the tree itself.
interface csa_tree_pipe_if import maf_pkg::*; #(
  parameter int W     = DEF_W,
  parameter int N_OPS = DEF_N_OPS,
  parameter int TAG_W = 4
);
  localparam int OW = ow_of(W, N_OPS);

  logic                 in_valid;
  logic                 in_ready;
  logic [N_OPS*W-1:0]   in_ops;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        sum_o;
  logic [OW-1:0]        carry_o;
  logic [TAG_W-1:0]     tag_o;

  modport master (
    output in_valid, in_ops, in_tag, out_ready,
    input  in_ready, out_valid, sum_o, carry_o, tag_o
  );

  modport slave (
    input  in_valid, in_ops, in_tag, out_ready,
    output in_ready, out_valid, sum_o, carry_o, tag_o
  );

endinterface

// File: rtl/comp42_row.sv
// One row of 4-2 compressor cells, purely combinational.
//   a, b, c, d : four OW-bit input vectors
//   sum        : row sum vector
//   carry      : row carry vector, already shifted left by one (bit 0 = 0)
// The cout of bit i feeds cin of bit i+1; cin of bit 0 is 0 and the cout
// and carry of the top bit fall off (arithmetic is modulo 2^OW).
module comp42_row #(
  parameter int OW = 19
) (
  input  logic [OW-1:0] a,
  input  logic [OW-1:0] b,
  input  logic [OW-1:0] c,
  input  logic [OW-1:0] d,
  output logic [OW-1:0] sum,
  output logic [OW-1:0] carry
);

  always_comb begin
    logic cin, x1, x2, x3;
    // NOTE: every output gets a default before the loop so no path leaves
    // a bit unassigned, which would otherwise infer a latch.
    sum   = '0;
    carry = '0;
    cin   = 1'b0;
    for (int i = 0; i < OW; i++) begin
      // NOTE: blocking assignments here are deliberate: cin must carry the
      // value computed for bit i into bit i+1 within the same evaluation.
      x1     = a[i] ^ b[i];
      x2     = c[i] ^ d[i];
      x3     = x1 ^ x2;
      sum[i] = x3 ^ cin;
      if (i < OW - 1) carry[i+1] = x3 ? cin : d[i];
      cin    = x1 ? c[i] : a[i];
    end
  end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction tree: N_OPS operands of W bits are reduced
// to a redundant sum/carry pair through L = clog2(N_OPS) - 1 levels of 4-2
// compressor rows, with one register stage per level.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every stage
//   bus  : csa_tree_pipe_if slave (valid/ready in, valid/ready out)
// N_OPS must be a power of two and at least 4.
module csa_tree_pipe import maf_pkg::*; #(
  parameter int W      = DEF_W,
  parameter int N_OPS  = DEF_N_OPS,
  parameter bit SIGNED = 1'b0,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  csa_tree_pipe_if.slave bus
);

  localparam int OW    = ow_of(W, N_OPS);
  localparam int L     = levels_of(N_OPS);
  localparam int N_REG = N_OPS - 2;      // vectors held across all stages
  localparam int N_SRC = 2 * N_OPS - 4;  // extended inputs + fed-back stages

  // src[0 .. N_OPS-1] are the extended operands; src[N_OPS + j] mirrors
  // stage slot j for every slot that feeds a further level.
  logic [N_SRC-1:0][OW-1:0]    src;
  logic [N_REG-1:0][OW-1:0]    row_out;
  logic [N_REG-1:0][OW-1:0]    stage_q;
  logic [L-1:0][TAG_W-1:0]     tag_q;
  logic [L-1:0][TAG_W-1:0]     tag_in;
  logic [L-1:0]                v;
  logic [L-1:0]                vin;
  logic [L-1:0]                adv;

  for (genvar k = 0; k < N_OPS; k++) begin : g_ext
    assign src[k] = OW'(extend_op(MAX_OW'(bus.in_ops[k*W +: W]), W, SIGNED));
  end

  for (genvar j = 0; j < N_OPS - 4; j++) begin : g_fb
    assign src[N_OPS + j] = stage_q[j];
  end

  // Level l consumes N_OPS >> l vectors starting at src index
  // 2*N_OPS - 2*(N_OPS >> l); row r takes four consecutive inputs and
  // writes its sum/carry into two consecutive slots of that level's bank.
  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int IN_BASE  = 2 * N_OPS - 2 * (N_OPS >> l);
    localparam int OUT_BASE = stage_base(N_OPS, l);
    localparam int ROWS     = (N_OPS >> l) / 4;
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      comp42_row #(.OW(OW)) u_row (
        .a     (src[IN_BASE + 4*r]),
        .b     (src[IN_BASE + 4*r + 1]),
        .c     (src[IN_BASE + 4*r + 2]),
        .d     (src[IN_BASE + 4*r + 3]),
        .sum   (row_out[OUT_BASE + 2*r]),
        .carry (row_out[OUT_BASE + 2*r + 1])
      );
    end
  end

  // Ready chain runs from the output back to the input: a stage advances
  // when it is empty or its successor advances. A local accumulator keeps
  // the chain free of self-referencing vector bits.
  always_comb begin
    logic chain;
    vin    = '0;
    tag_in = '0;
    adv    = '0;
    vin[0]    = bus.in_valid;
    tag_in[0] = bus.in_tag;
    for (int l = 1; l < L; l++) begin
      vin[l]    = v[l-1];
      tag_in[l] = tag_q[l-1];
    end
    chain    = !v[L-1] || bus.out_ready;
    adv[L-1] = chain;
    for (int s = L - 2; s >= 0; s--) begin
      chain  = !v[s] || chain;
      adv[s] = chain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v       <= '0;
      // NOTE: the data and tag banks are reset too, because the result
      // ports are driven straight from them and must read zero after reset.
      stage_q <= '0;
      tag_q   <= '0;
    end else begin
      for (int l = 0; l < L; l++) begin
        if (adv[l]) begin
          // NOTE: non-blocking updates let every stage sample its
          // predecessor's pre-edge contents, so data shifts one stage per edge.
          v[l] <= vin[l];
          // Payload loads only with a real transaction; bubbles leave it be.
          if (vin[l]) begin
            tag_q[l] <= tag_in[l];
            for (int j = 0; j < N_REG; j++) begin
              if (j >= stage_base(N_OPS, l) && j < stage_base(N_OPS, l + 1))
                stage_q[j] <= row_out[j];
            end
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[L-1];
  assign bus.sum_o     = stage_q[N_OPS-4];
  assign bus.carry_o   = stage_q[N_OPS-3];
  assign bus.tag_o     = tag_q[L-1];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: three builds (8 ops unsigned,
// 8 ops signed, 4 ops signed) share clock and reset. Expected results are
// queued when a vector is accepted and compared when it leaves the tree.
module tb_csa_tree_pipe;

  typedef struct {
    logic [18:0] sum;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csa_tree_pipe_if #(.W(16), .N_OPS(8), .TAG_W(4)) b8u ();
  csa_tree_pipe_if #(.W(16), .N_OPS(8), .TAG_W(4)) b8s ();
  csa_tree_pipe_if #(.W(16), .N_OPS(4), .TAG_W(4)) b4s ();

  csa_tree_pipe #(.W(16), .N_OPS(8), .SIGNED(1'b0), .TAG_W(4)) dut8u (
    .clk(clk), .rst(rst), .bus(b8u.slave));
  csa_tree_pipe #(.W(16), .N_OPS(8), .SIGNED(1'b1), .TAG_W(4)) dut8s (
    .clk(clk), .rst(rst), .bus(b8s.slave));
  csa_tree_pipe #(.W(16), .N_OPS(4), .SIGNED(1'b1), .TAG_W(4)) dut4s (
    .clk(clk), .rst(rst), .bus(b4s.slave));

  exp_t q8u[$];
  exp_t q8s[$];
  exp_t q4s[$];
  exp_t e8u, e8s, e4s;
  int checks   = 0;
  int failures = 0;
  int n8u = 0, n8s = 0, n4s = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum of the extended operands, modulo 2^19.
  function automatic logic [18:0] ref8(input logic [127:0] ops, input bit sgn);
    int total;
    total = 0;
    for (int k = 0; k < 8; k++) begin
      if (sgn) total += int'($signed(ops[k*16 +: 16]));
      else     total += int'(ops[k*16 +: 16]);
    end
    return 19'(total);
  endfunction

  // Offer one vector to the unsigned 8-op build and wait (bounded) for it
  // to be accepted; the expected result is queued on the accepting edge.
  task automatic send8u(input logic [127:0] ops, input logic [3:0] tag,
                        input logic [18:0] exp_sum, input bit chk);
    int budget;
    budget = 0;
    b8u.in_valid = 1'b1;
    b8u.in_ops   = ops;
    b8u.in_tag   = tag;
    while (1) begin
      @(negedge clk);
      if (chk) begin
        check("stream_out_valid", 64'(b8u.out_valid), 64'(1));
        check("stream_in_ready", 64'(b8u.in_ready), 64'(1));
      end
      if (b8u.in_ready) break;
      budget++;
      if (budget > 50) begin
        check("send_timeout", 64'(0), 64'(1));
        b8u.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    q8u.push_back('{sum: exp_sum, tag: tag});
    #1 b8u.in_valid = 1'b0;
  endtask

  // Output monitors: a result is consumed on the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!rst && b8u.out_valid && b8u.out_ready) begin
      if (q8u.size() == 0) check("8u_unexpected_result", 64'(1), 64'(0));
      else begin
        e8u = q8u.pop_front();
        check("8u_sum", 64'(19'(b8u.sum_o + b8u.carry_o)), 64'(e8u.sum));
        check("8u_tag", 64'(b8u.tag_o), 64'(e8u.tag));
        n8u++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b8s.out_valid && b8s.out_ready) begin
      if (q8s.size() == 0) check("8s_unexpected_result", 64'(1), 64'(0));
      else begin
        e8s = q8s.pop_front();
        check("8s_sum", 64'(19'(b8s.sum_o + b8s.carry_o)), 64'(e8s.sum));
        check("8s_tag", 64'(b8s.tag_o), 64'(e8s.tag));
        n8s++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b4s.out_valid && b4s.out_ready) begin
      if (q4s.size() == 0) check("4s_unexpected_result", 64'(1), 64'(0));
      else begin
        e4s = q4s.pop_front();
        check("4s_sum", 64'(18'(b4s.sum_o + b4s.carry_o)), 64'(e4s.sum[17:0]));
        check("4s_tag", 64'(b4s.tag_o), 64'(e4s.tag));
        n4s++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] ops;
    logic [18:0]  snap_sum, snap_carry;
    logic [3:0]   snap_tag;

    b8u.in_valid = 1'b0; b8u.in_ops = '0; b8u.in_tag = '0; b8u.out_ready = 1'b1;
    b8s.in_valid = 1'b0; b8s.in_ops = '0; b8s.in_tag = '0; b8s.out_ready = 1'b1;
    b4s.in_valid = 1'b0; b4s.in_ops = '0; b4s.in_tag = '0; b4s.out_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(b8u.in_ready), 64'(1));
    check("rst_out_valid", 64'(b8u.out_valid), 64'(0));
    check("rst_sum", 64'(b8u.sum_o), 64'(0));
    check("rst_carry", 64'(b8u.carry_o), 64'(0));
    check("rst_tag", 64'(b8u.tag_o), 64'(0));
    check("rst_8s_out_valid", 64'(b8s.out_valid), 64'(0));
    check("rst_4s_in_ready", 64'(b4s.in_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All-ones unsigned vector: two-cycle latency, 8 * 0xFFFF = 0x7FFF8
    send8u({8{16'hFFFF}}, 4'h5, 19'h7FFF8, 1'b0);
    @(negedge clk);
    check("lat8_cycle1_out_valid", 64'(b8u.out_valid), 64'(0));
    @(negedge clk);
    check("lat8_cycle2_out_valid", 64'(b8u.out_valid), 64'(1));
    check("lat8_tag", 64'(b8u.tag_o), 64'(5));
    @(posedge clk);
    #1;

    // Same vector through signed and unsigned builds, plus the 4-op build
    ops = {96'h0, 16'h0001, 16'hFFFF};
    b8s.in_valid = 1'b1; b8s.in_ops = ops; b8s.in_tag = 4'hA;
    q8s.push_back('{sum: 19'h00000, tag: 4'hA});
    b4s.in_valid = 1'b1; b4s.in_ops = {4{16'h8000}}; b4s.in_tag = 4'h7;
    q4s.push_back('{sum: 19'h20000, tag: 4'h7});
    send8u(ops, 4'h3, 19'h10000, 1'b0);
    b8s.in_valid = 1'b0;
    b4s.in_valid = 1'b0;
    @(negedge clk);
    check("lat4_cycle1_out_valid", 64'(b4s.out_valid), 64'(1));
    check("lat8s_cycle1_out_valid", 64'(b8s.out_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back random stream, one result per cycle
    for (int i = 0; i < 100; i++) begin
      ops = {$urandom, $urandom, $urandom, $urandom};
      send8u(ops, 4'(i), ref8(ops, 1'b0), i >= 2);
    end
    repeat (4) @(posedge clk);
    #1;
    check("stream_count", 64'(n8u), 64'(102));

    // Back-pressure: two accepted, third refused until the sink is ready
    b8u.out_ready = 1'b0;
    ops = {$urandom, $urandom, $urandom, $urandom};
    send8u(ops, 4'h1, ref8(ops, 1'b0), 1'b0);
    snap_sum = ref8(ops, 1'b0);
    ops = {$urandom, $urandom, $urandom, $urandom};
    send8u(ops, 4'h2, ref8(ops, 1'b0), 1'b0);
    ops = {$urandom, $urandom, $urandom, $urandom};
    b8u.in_valid = 1'b1; b8u.in_ops = ops; b8u.in_tag = 4'h3;
    @(negedge clk);
    check("bp_in_ready_full", 64'(b8u.in_ready), 64'(0));
    check("bp_out_valid", 64'(b8u.out_valid), 64'(1));
    check("bp_head_tag", 64'(b8u.tag_o), 64'(1));
    check("bp_head_sum", 64'(19'(b8u.sum_o + b8u.carry_o)), 64'(snap_sum));
    snap_sum = b8u.sum_o; snap_carry = b8u.carry_o; snap_tag = b8u.tag_o;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_held", 64'(b8u.in_ready), 64'(0));
      check("bp_sum_stable", 64'(b8u.sum_o), 64'(snap_sum));
      check("bp_carry_stable", 64'(b8u.carry_o), 64'(snap_carry));
      check("bp_tag_stable", 64'(b8u.tag_o), 64'(snap_tag));
    end
    @(posedge clk);
    #1 b8u.out_ready = 1'b1;
    #1 check("bp_passthru_in_ready", 64'(b8u.in_ready), 64'(1));
    @(posedge clk);
    q8u.push_back('{sum: ref8(ops, 1'b0), tag: 4'h3});
    #1 b8u.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drain_count", 64'(n8u), 64'(105));

    // Reset between edges with a full pipe
    b8u.out_ready = 1'b0;
    ops = {$urandom, $urandom, $urandom, $urandom};
    send8u(ops, 4'hD, ref8(ops, 1'b0), 1'b0);
    ops = {$urandom, $urandom, $urandom, $urandom};
    send8u(ops, 4'hE, ref8(ops, 1'b0), 1'b0);
    @(negedge clk);
    check("rstmid_full_in_ready", 64'(b8u.in_ready), 64'(0));
    #2 rst = 1'b1;
    #1;
    check("rstmid_out_valid", 64'(b8u.out_valid), 64'(0));
    check("rstmid_sum", 64'(b8u.sum_o), 64'(0));
    check("rstmid_carry", 64'(b8u.carry_o), 64'(0));
    check("rstmid_tag", 64'(b8u.tag_o), 64'(0));
    check("rstmid_in_ready", 64'(b8u.in_ready), 64'(1));
    #1 rst = 1'b0;
    q8u.delete();
    b8u.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rstmid_no_stale", 64'(b8u.out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    ops = {$urandom, $urandom, $urandom, $urandom};
    send8u(ops, 4'h9, ref8(ops, 1'b0), 1'b0);
    repeat (4) @(posedge clk);
    #1;

    check("final_8u_count", 64'(n8u), 64'(106));
    check("final_8s_count", 64'(n8s), 64'(1));
    check("final_4s_count", 64'(n4s), 64'(1));
    check("final_8u_queue_empty", 64'(q8u.size()), 64'(0));
    check("final_8s_queue_empty", 64'(q8s.size()), 64'(0));
    check("final_4s_queue_empty", 64'(q4s.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_tree_pipe.md
# csa_tree_pipe

Parametrised, pipelined carry-save reduction tree for the MAF datapath. It reduces N_OPS partial-product operands of width W to a redundant sum/carry pair by cascading rows of 4-2 compressor cells, with one register stage after each row-level. Valid/ready handshakes on both sides let it stall under back-pressure. It sits between the partial-product generator and the final carry-propagate adder.

## Interface
- W, default 16: operand width in bits.
- N_OPS, default 8: operand count; must be a power of two and at least 4.
- SIGNED, default 0: 1 sign-extends operands, 0 zero-extends them.
- TAG_W, default 4: width of the side-band tag carried alongside each transaction.
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand vector presented.
- in_ready  output  1  block accepts the vector this cycle.
- in_ops  input  N_OPS*W  packed operands; operand k occupies bits [k*W +: W].
- in_tag  input  TAG_W  tag returned unchanged with the result.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- sum_o  output  OW  redundant sum vector, where OW = W + clog2(N_OPS).
- carry_o  output  OW  redundant carry vector, already weight-aligned.
- tag_o  output  TAG_W  tag of the presented result.

## Operation
- Operands are extended to OW bits at the input, by sign or by zero according to SIGNED.
- Number of levels: L = clog2(N_OPS) - 1. Each level maps 4 vectors to 2 with one 4-2 cell per bit.
- Per cell: x1 = a^b, x2 = c^d, x3 = x1^x2.
  - sum = x3 ^ cin.
  - cout = x1 ? c : a.
  - carry = x3 ? cin : d.
- Horizontal chain: cout of bit i drives cin of bit i+1. cin of bit 0 is 0. cout of bit OW-1 is dropped.
- The row's carry vector is shifted left by 1 with a 0 inserted at bit 0. Bit OW-1 is dropped.
- A level with 2M input vectors uses M/2 rows. Rows pair their inputs in ascending index order.
- Arithmetic is modulo 2^OW. Required invariant: (sum_o + carry_o) mod 2^OW equals the sum of the extended operands mod 2^OW.
- Handshake:
  - A transfer occurs on any cycle where valid and ready are both high.
  - Stage s advances when it is empty or when stage s+1 advances. The last stage advances when out_ready is high.
  - in_ready = !v[0] || adv[0]. This is a combinational ready chain; no skid buffer.
  - out_valid = v[L-1].
  - sum_o, carry_o and tag_o come directly from the last stage register.
- Outputs hold stable while out_valid && !out_ready.
- Results are delivered strictly in input order. The block never drops or duplicates a transaction.

## Timing
- Latency is L cycles from input acceptance to out_valid, with no stall. For N_OPS=8 this is 2 cycles; for N_OPS=4 it is 1 cycle.
- Throughput is one transaction per cycle while out_ready is held high.
- Capacity is L transactions. With out_ready low, in_ready falls once all L stages are full.
- When the last stage is full and out_ready is high, a new input is accepted in the same cycle (full-pipe pass-through).
- Reset state: all stage valids are 0; all data and tag registers are 0. Therefore in_ready=1, out_valid=0, sum_o=0, carry_o=0, tag_o=0.
- Reset asserted mid-operation clears all stages immediately, without waiting for a clock edge. In-flight transactions are discarded.
- On the first edge after rst deasserts, the block accepts input normally.
- in_ops and in_tag are ignored when in_valid=0. Stage registers load only when their stage advances.

## Structure
- Shared package maf_pkg holds:
  - the clog2 function;
  - localparam helpers for OW and L;
  - the operand extension function, taking SIGNED as an argument.
- Sub-module comp42_row(width OW): one row of the team's existing 4-2 compressor cells. It wires the cout→cin chain and applies the carry shift. It is purely combinational.
- The top level uses a generate loop over levels and rows, with one register bank and one valid bit per level.

## Test plan
- Unsigned, N_OPS=8, W=16: all operands 0xFFFF, tag 0x5 → after 2 cycles, sum_o+carry_o mod 2^19 = 0x7FFF8 and tag_o = 0x5.
- SIGNED=1: operands {0xFFFF, 0x0001, 0,0,0,0,0,0} → sum 0. The same vector with SIGNED=0 → 0x10000.
- Streaming: 100 random vectors back-to-back with out_ready=1 → one result per cycle, in order, each matching the reference-model sum. out_valid stays high continuously after the first 2 cycles.
- Back-pressure: out_ready=0, three vectors offered on consecutive cycles → two accepted, in_ready=0 on the third. sum_o, carry_o and tag_o hold stable. After out_ready=1, all three drain in order.
- Reset mid-flight: pipe full, rst pulsed between clock edges → out_valid, sum_o, carry_o and tag_o go to 0 immediately and in_ready=1. No stale result appears after release.
- N_OPS=4 build: latency is 1 cycle. Operands {0x8000, 0x8000, 0x8000, 0x8000} with SIGNED=1 give sum mod 2^18 = 0x20000.
